// File: rtl/alu_seq.sv
// Registered multi-cycle 6502-style ALU: operand-A mux, binary op set with NZVC flags,
// and an extra NMOS-style BCD adjust cycle for decimal ADC/SBC at WIDTH==8.
module alu_seq #(
  parameter int WIDTH    = 8,
  parameter int NUM_ARGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [3:0]                op,
  input  logic [SEL_W-1:0]          arg_sel,
  input  logic [NUM_ARGS*WIDTH-1:0] args,
  input  logic [WIDTH-1:0]          data_in,
  input  logic [3:0]                flags_in,
  input  logic                      decimal,
  output logic [WIDTH-1:0]          data_out,
  output logic [3:0]                flags_out,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_dbg
);

  // Handshake: start is taken only in IDLE while done is low; operands are captured on
  // that edge. busy is high while an op is in flight, done pulses for exactly one cycle
  // with busy low, and data_out/flags_out hold their value until the next done.

  localparam logic [3:0] OP_INC  = 4'd0;
  localparam logic [3:0] OP_DEC  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_ORA  = 4'd5;
  localparam logic [3:0] OP_EOR  = 4'd6;
  localparam logic [3:0] OP_ASL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;

  localparam logic             DEC_OK = (WIDTH == 8);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ADJ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic             accept;
  logic             dec_path;
  logic [WIDTH-1:0] a_sel;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       fl_q;
  logic             dec_q;
  logic             c_in;

  logic [WIDTH-1:0] res_q;
  logic [3:0]       fres_q;

  logic [WIDTH:0]   sum_ab, sub_ab, cmp_ab;
  logic [WIDTH-1:0] ex_res, nz_val;
  logic             ex_c, ex_v, nz_keep;
  logic [3:0]       ex_flags;

  logic [7:0]       d_a, d_b;
  logic [4:0]       lo_sum;
  logic [8:0]       ad_bin, sb_bin;
  logic [9:0]       ad_lo;
  logic             ad_hi, lo_borrow;
  logic [7:0]       adc_res, sbc_res, d_res;
  logic             d_c;

  assign c_in     = fl_q[0];
  assign dec_path = DEC_OK && dec_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

  // Out-of-range selects fall back to arg 0.
  always_comb begin
    a_sel = args[0 +: WIDTH];
    for (int i = 1; i < NUM_ARGS; i++) begin
      if (int'(arg_sel) == i) a_sel = args[i*WIDTH +: WIDTH];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_EXEC;
      S_EXEC:  state_nx = dec_path ? S_ADJ : S_DONE;
      S_ADJ:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != S_IDLE);
    accept    = (state == S_IDLE) && start && !done;
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      fl_q  <= '0;
      dec_q <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      a_q   <= a_sel;
      b_q   <= data_in;
      fl_q  <= flags_in;
      dec_q <= decimal;
    end
  end

  // Binary result; N/Z come from nz_val so CMP can report the difference while returning A.
  always_comb begin
    sum_ab  = {1'b0, a_q} + {1'b0, b_q}  + {{WIDTH{1'b0}}, c_in};
    sub_ab  = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, c_in};
    cmp_ab  = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    ex_res  = '1;
    ex_c    = fl_q[0];
    ex_v    = fl_q[2];
    nz_keep = 1'b0;
    case (op_q)
      OP_INC:  ex_res = a_q + ONE;
      OP_DEC:  ex_res = a_q - ONE;
      OP_ADC: begin
        ex_res = sum_ab[WIDTH-1:0];
        ex_c   = sum_ab[WIDTH];
        ex_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ab[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SBC: begin
        ex_res = sub_ab[WIDTH-1:0];
        ex_c   = sub_ab[WIDTH];
        ex_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ab[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  ex_res = a_q & b_q;
      OP_ORA:  ex_res = a_q | b_q;
      OP_EOR:  ex_res = a_q ^ b_q;
      OP_ASL: begin
        ex_res = {a_q[WIDTH-2:0], 1'b0};
        ex_c   = a_q[WIDTH-1];
      end
      OP_LSR: begin
        ex_res = {1'b0, a_q[WIDTH-1:1]};
        ex_c   = a_q[0];
      end
      OP_ROL: begin
        ex_res = {a_q[WIDTH-2:0], c_in};
        ex_c   = a_q[WIDTH-1];
      end
      OP_ROR: begin
        ex_res = {c_in, a_q[WIDTH-1:1]};
        ex_c   = a_q[0];
      end
      OP_PASS: ex_res = a_q;
      OP_CMP: begin
        ex_res = a_q;
        ex_c   = cmp_ab[WIDTH];
      end
      default: nz_keep = 1'b1;
    endcase
    nz_val   = (op_q == OP_CMP) ? cmp_ab[WIDTH-1:0] : ex_res;
    ex_flags = nz_keep ? fl_q : {nz_val[WIDTH-1], ex_v, (nz_val == '0), ex_c};
  end

  // BCD correction, only consumed when WIDTH==8; the carry test runs after the +0x06 step.
  always_comb begin
    d_a       = 8'(a_q);
    d_b       = 8'(b_q);
    lo_sum    = {1'b0, d_a[3:0]} + {1'b0, d_b[3:0]} + {4'd0, c_in};
    ad_bin    = {1'b0, d_a} + {1'b0, d_b} + {8'd0, c_in};
    ad_lo     = {1'b0, ad_bin} + ((lo_sum > 5'd9) ? 10'h006 : 10'h000);
    ad_hi     = (ad_lo[7:4] > 4'd9) || (ad_lo[9:8] != 2'b00);
    adc_res   = ad_lo[7:0] + (ad_hi ? 8'h60 : 8'h00);
    lo_borrow = {1'b0, d_a[3:0]} < ({1'b0, d_b[3:0]} + {4'd0, ~c_in});
    sb_bin    = {1'b0, d_a} + {1'b0, ~d_b} + {8'd0, c_in};
    sbc_res   = sb_bin[7:0] - (lo_borrow ? 8'h06 : 8'h00) - (sb_bin[8] ? 8'h00 : 8'h60);
    d_res     = (op_q == OP_SBC) ? sbc_res : adc_res;
    d_c       = (op_q == OP_SBC) ? sb_bin[8] : ad_hi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q     <= '0;
      fres_q    <= '0;
      data_out  <= '0;
      flags_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_EXEC: begin
          res_q  <= ex_res;
          fres_q <= ex_flags;
        end
        S_ADJ: begin
          res_q  <= WIDTH'(d_res);
          fres_q <= {d_res[7], fres_q[2], (d_res == 8'h00), d_c};
        end
        S_DONE: begin
          data_out  <= res_q;
          flags_out <= fres_q;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written handshake/reset sequences,
// randomized ops against an arithmetic reference model, and a WIDTH=16 instance.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [1:0]  arg_sel;
  logic [31:0] args;
  logic [7:0]  data_in;
  logic [3:0]  flags_in;
  logic        decimal;
  logic [7:0]  data_out;
  logic [3:0]  flags_out;
  logic        busy, done;
  logic [1:0]  state_dbg;

  logic        start_w;
  logic [3:0]  op_w;
  logic [1:0]  arg_sel_w;
  logic [63:0] args_w;
  logic [15:0] data_in_w;
  logic [3:0]  flags_in_w;
  logic        decimal_w;
  logic [15:0] data_out_w;
  logic [3:0]  flags_out_w;
  logic        busy_w, done_w;
  logic [1:0]  state_dbg_w;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [3:0] op;
    logic [1:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] fl;
    logic       dec;
    logic [7:0] exp_res;
    logic [3:0] exp_fl;
    int         exp_lat;
  } vec_t;

  vec_t vecs[14];

  alu_seq #(.WIDTH(8), .NUM_ARGS(4), .SEL_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .arg_sel(arg_sel),
    .args(args), .data_in(data_in), .flags_in(flags_in), .decimal(decimal),
    .data_out(data_out), .flags_out(flags_out), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  alu_seq #(.WIDTH(16), .NUM_ARGS(4), .SEL_W(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(start_w), .op(op_w), .arg_sel(arg_sel_w),
    .args(args_w), .data_in(data_in_w), .flags_in(flags_in_w), .decimal(decimal_w),
    .data_out(data_out_w), .flags_out(flags_out_w), .busy(busy_w), .done(done_w),
    .state_dbg(state_dbg_w)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [1:0] s, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] f, input logic d,
                              input logic [7:0] er, input logic [3:0] ef, input int el);
    vec_t v;
    v.op = o; v.sel = s; v.a = a; v.b = b; v.fl = f; v.dec = d;
    v.exp_res = er; v.exp_fl = ef; v.exp_lat = el;
    return v;
  endfunction

  function automatic int bcd_val(input int x);
    return (x / 16) * 10 + (x % 16);
  endfunction

  function automatic int to_bcd(input int x);
    return (x / 10) * 16 + (x % 10);
  endfunction

  // Reference model: returns {result, N, V, Z, C} from plain integer arithmetic.
  function automatic logic [11:0] model(input int o, input int a, input int b,
                                        input logic [3:0] fl, input logic dec);
    int c, v, cc, r, nz, s, sa, sb;
    c  = int'(fl[0]);
    v  = int'(fl[2]);
    cc = c;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r  = a;
    case (o)
      0: r = (a + 1) % 256;
      1: r = (a + 255) % 256;
      2: begin
        s = sa + sb + c;
        v = (s > 127 || s < -128) ? 1 : 0;
        if (dec) begin
          s = bcd_val(a) + bcd_val(b) + c;
          cc = (s > 99) ? 1 : 0;
          r = to_bcd(s % 100);
        end else begin
          s = a + b + c;
          cc = (s > 255) ? 1 : 0;
          r = s % 256;
        end
      end
      3: begin
        s = sa - sb - (1 - c);
        v = (s > 127 || s < -128) ? 1 : 0;
        if (dec) begin
          s = bcd_val(a) - bcd_val(b) - (1 - c);
          cc = (s >= 0) ? 1 : 0;
          r = to_bcd((s + 100) % 100);
        end else begin
          s = a - b - (1 - c);
          cc = (s >= 0) ? 1 : 0;
          r = (s + 256) % 256;
        end
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: begin cc = a / 128; r = (a * 2) % 256; end
      8: begin cc = a % 2;   r = a / 2; end
      9: begin cc = a / 128; r = (a * 2 + c) % 256; end
      10: begin cc = a % 2;  r = a / 2 + c * 128; end
      11: r = a;
      12: begin cc = (a >= b) ? 1 : 0; r = a; end
      default: return {8'hFF, fl};
    endcase
    nz = (o == 12) ? (a - b + 256) % 256 : r;
    return {8'(r), (nz > 127), 1'(v), (nz == 0), 1'(cc)};
  endfunction

  // Driver: issue one op, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [3:0] o, input logic [1:0] s, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] f, input logic d,
                        output logic [7:0] res, output logic [3:0] fo, output int lat);
    @(negedge clk);
    op = o; arg_sel = s; data_in = b; flags_in = f; decimal = d;
    args = $urandom();
    args[s*8 +: 8] = a;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); args = $urandom(); data_in = 8'($urandom);
    flags_in = 4'($urandom); decimal = 1'($urandom);
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    res = data_out;
    fo  = flags_out;
  endtask

  initial begin
    logic [7:0]  res, a, b;
    logic [3:0]  fo, o, f;
    logic [1:0]  s;
    logic        d, saw;
    logic [11:0] got;
    int          lat, elat, n_done, n_overlap;

    // Clock / reset
    reset_n = 1'b0; start = 1'b0; op = '0; arg_sel = '0; args = '0; data_in = '0;
    flags_in = '0; decimal = 1'b0;
    start_w = 1'b0; op_w = '0; arg_sel_w = '0; args_w = '0; data_in_w = '0;
    flags_in_w = '0; decimal_w = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_flags", 32'(flags_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_w16_data", 32'(data_out_w), 32'h0);
    reset_n = 1'b1;

    // Directed vector table
    vecs[0]  = mk(4'd0,  2'd2, 8'hFF, 8'h00, 4'b0101, 1'b0, 8'h00, 4'b0111, 3);
    vecs[1]  = mk(4'd2,  2'd0, 8'h50, 8'h50, 4'b0000, 1'b0, 8'hA0, 4'b1100, 3);
    vecs[2]  = mk(4'd2,  2'd1, 8'h58, 8'h46, 4'b0001, 1'b1, 8'h05, 4'b0101, 4);
    vecs[3]  = mk(4'd3,  2'd3, 8'h12, 8'h21, 4'b0001, 1'b1, 8'h91, 4'b1000, 4);
    vecs[4]  = mk(4'd10, 2'd0, 8'h01, 8'h00, 4'b0001, 1'b0, 8'h80, 4'b1001, 3);
    vecs[5]  = mk(4'd12, 2'd1, 8'h10, 8'h20, 4'b0000, 1'b0, 8'h10, 4'b1000, 3);
    vecs[6]  = mk(4'd14, 2'd2, 8'h33, 8'h44, 4'b1010, 1'b0, 8'hFF, 4'b1010, 3);
    vecs[7]  = mk(4'd1,  2'd3, 8'h00, 8'h00, 4'b0000, 1'b0, 8'hFF, 4'b1000, 3);
    vecs[8]  = mk(4'd8,  2'd0, 8'h01, 8'h00, 4'b0000, 1'b0, 8'h00, 4'b0011, 3);
    vecs[9]  = mk(4'd12, 2'd2, 8'h42, 8'h42, 4'b0000, 1'b0, 8'h42, 4'b0011, 3);
    vecs[10] = mk(4'd3,  2'd1, 8'h80, 8'h01, 4'b0001, 1'b0, 8'h7F, 4'b0101, 3);
    vecs[11] = mk(4'd7,  2'd3, 8'h80, 8'h00, 4'b0000, 1'b0, 8'h00, 4'b0011, 3);
    vecs[12] = mk(4'd2,  2'd0, 8'h99, 8'h01, 4'b0000, 1'b1, 8'h00, 4'b0011, 4);
    vecs[13] = mk(4'd6,  2'd2, 8'hF0, 8'hFF, 4'b0110, 1'b0, 8'h0F, 4'b0100, 3);
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].fl, vecs[i].dec, res, fo, lat);
      chk($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d_flags", i), 32'(fo), 32'(vecs[i].exp_fl));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Randomized ops against the reference model (scoreboard queue)
    for (int i = 0; i < 200; i++) begin
      o = 4'($urandom_range(0, 15));
      s = 2'($urandom_range(0, 3));
      f = 4'($urandom);
      d = 1'($urandom_range(0, 1));
      if (d && (o == 4'd2 || o == 4'd3)) begin
        a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      exp_q.push_back(model(int'(o), int'(a), int'(b), f, d));
      elat = (d && (o == 4'd2 || o == 4'd3)) ? 4 : 3;
      run_op(o, s, a, b, f, d, res, fo, lat);
      got = exp_q.pop_front();
      chk($sformatf("rand%0d_op%0d_data", i, o), 32'(res), 32'(got[11:4]));
      chk($sformatf("rand%0d_op%0d_flags", i, o), 32'(fo), 32'(got[3:0]));
      chk($sformatf("rand%0d_op%0d_latency", i, o), 32'(lat), 32'(elat));
    end

    // Put non-zero state in the output registers, then reset in the middle of EXEC
    run_op(4'd11, 2'd1, 8'h5A, 8'h00, 4'b0101, 1'b0, res, fo, lat);
    chk("pre_reset_data", 32'(res), 32'h5A);
    chk("pre_reset_flags", 32'(fo), 32'h5);
    @(negedge clk);
    op = 4'd0; arg_sel = 2'd0; args = 32'h0000_0010; flags_in = 4'b0000; decimal = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("midop_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_data", 32'(data_out), 32'h0);
    chk("abort_flags", 32'(flags_out), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("abort_no_done", 32'(saw), 32'h0);

    // start held high for 12 cycles: one op per four cycles, busy low with done
    op = 4'd11; arg_sel = 2'd0; args = 32'h0000_0077; flags_in = 4'b0000; decimal = 1'b0;
    start = 1'b1;
    n_done = 0;
    n_overlap = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
      if (busy && done) n_overlap++;
    end
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy && done) n_overlap++;
    end
    chk("stream_done_count", 32'(n_done), 32'd3);
    chk("stream_busy_with_done", 32'(n_overlap), 32'd0);
    chk("stream_data", 32'(data_out), 32'h77);

    // WIDTH=16 instance: INC wrap, and decimal ADC handled as binary
    @(negedge clk);
    op_w = 4'd0; arg_sel_w = 2'd0; args_w = {16'h1234, 16'h0058, 16'h7777, 16'hFFFF};
    flags_in_w = 4'b0000; decimal_w = 1'b0; start_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w = 1'b0;
    lat = 1;
    while (!done_w && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("w16_inc_data", 32'(data_out_w), 32'h0000);
    chk("w16_inc_flags", 32'(flags_out_w), 32'b0010);
    chk("w16_inc_latency", 32'(lat), 32'd3);

    @(negedge clk);
    op_w = 4'd2; arg_sel_w = 2'd2; data_in_w = 16'h0046; flags_in_w = 4'b0001;
    decimal_w = 1'b1; start_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_w = 1'b0;
    lat = 1;
    while (!done_w && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("w16_dec_adc_data", 32'(data_out_w), 32'h009F);
    chk("w16_dec_adc_flags", 32'(flags_out_w), 32'b0000);
    chk("w16_dec_adc_latency", 32'(lat), 32'd3);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
